// File: rtl/param_cache.sv
// param_cache: set-associative, write-back / write-allocate cache for a
// 16-bit CPU. Each line holds 128 bits (eight 16-bit words). Replacement
// uses per-set age counters that form a true-LRU permutation.
module param_cache #(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 12 - IDXW;
    localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AGEW = WAYW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    state_t r_state;

    // Per-way, per-set storage
    logic            r_valid [WAYS][SETS];
    logic            r_dirty [WAYS][SETS];
    logic [TAGW-1:0] r_tag   [WAYS][SETS];
    logic [127:0]    r_line  [WAYS][SETS];
    logic [AGEW-1:0] r_age   [WAYS][SETS];

    // Victim is frozen when a miss leaves CHECK so fills/writebacks are stable
    logic [WAYW-1:0] r_victim;

    logic [IDXW-1:0] w_idx;
    logic [TAGW-1:0] w_tag;
    logic [2:0]      w_off;
    logic            w_unused;
    logic            w_hit;
    logic [WAYW-1:0] w_hit_way;
    logic [WAYW-1:0] w_vic;
    logic            w_vic_found;
    logic [127:0]    w_hit_line;
    logic [127:0]    w_merge;

    assign w_idx    = mem_address[3+IDXW:4];
    assign w_tag    = mem_address[15:4+IDXW];
    assign w_off    = mem_address[3:1];
    assign w_unused = mem_address[0];

    // Tag compare across all ways of the addressed set
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_hit && r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAYW'(w);
            end
        end
    end

    // Victim choice: first empty way, otherwise the oldest way
    always_comb begin
        w_vic_found = 1'b0;
        w_vic       = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_vic_found && !r_valid[w][w_idx]) begin
                w_vic_found = 1'b1;
                w_vic       = WAYW'(w);
            end
        end
        if (!w_vic_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (r_age[w][w_idx] == AGEW'(WAYS - 1)) begin
                    w_vic = WAYW'(w);
                end
            end
        end
    end

    // Read word select and byte-masked write merge on the hit line
    always_comb begin
        w_hit_line = r_line[w_hit_way][w_idx];
        mem_rdata  = w_hit_line[{w_off, 4'b0000} +: 16];
        w_merge    = w_hit_line;
        if (mem_byte_enable[0]) w_merge[{w_off, 4'b0000} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1]) w_merge[{w_off, 4'b1000} +: 8] = mem_wdata[15:8];
    end

    // Output decode from the registered state; strobes are idle outside transfers
    always_comb begin
        mem_resp     = (r_state == S_CHECK) && w_hit;
        pmem_read    = (r_state == S_ALLOCATE);
        pmem_write   = (r_state == S_WRITEBACK);
        pmem_wdata   = r_line[r_victim][w_idx];
        pmem_address = '0;
        if (r_state == S_WRITEBACK) pmem_address = {r_tag[r_victim][w_idx], w_idx, 4'b0000};
        if (r_state == S_ALLOCATE)  pmem_address = {w_tag, w_idx, 4'b0000};
    end

    // Controller FSM with tag/data/LRU updates; line data and tags survive reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                    r_age[w][s]   <= AGEW'(w);
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_read || mem_write) r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_hit) begin
                        // A simultaneous read+write is handled as a write
                        if (mem_write) begin
                            r_line[w_hit_way][w_idx]  <= w_merge;
                            r_dirty[w_hit_way][w_idx] <= 1'b1;
                        end
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAYW'(w) == w_hit_way)
                                r_age[w][w_idx] <= '0;
                            else if (r_age[w][w_idx] < r_age[w_hit_way][w_idx])
                                r_age[w][w_idx] <= r_age[w][w_idx] + 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_victim <= w_vic;
                        r_state  <= r_dirty[w_vic][w_idx] ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
                S_WRITEBACK: begin
                    if (pmem_resp) begin
                        r_dirty[r_victim][w_idx] <= 1'b0;
                        r_state                  <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    if (pmem_resp) begin
                        r_line[r_victim][w_idx]  <= pmem_rdata;
                        r_tag[r_victim][w_idx]   <= w_tag;
                        r_valid[r_victim][w_idx] <= 1'b1;
                        r_dirty[r_victim][w_idx] <= 1'b0;
                        r_state                  <= S_CHECK;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/param_cache.md
PARAM_CACHE -- requirements
Module: param_cache

Interface
REQ-001 Parameter WAYS, default 2, associativity; legal values 1, 2, 4, 8.
REQ-002 Parameter SETS, default 8, sets per way; power of two, 2..64; IDXW = log2(SETS), TAGW = 12 - IDXW.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 mem_address  in  16  CPU byte address; [3:1] word offset, [3+IDXW:4] index, [15:4+IDXW] tag.
REQ-006 mem_read / mem_write  in  1 each  CPU request strobes, held until mem_resp.
REQ-007 mem_byte_enable  in  2  write mask; bit0 low byte, bit1 high byte.
REQ-008 mem_wdata  in  16  CPU write word.
REQ-009 mem_rdata  out  16  addressed word of hit line.
REQ-010 mem_resp  out  1  one-cycle completion pulse.
REQ-011 pmem_address  out  16  line address, [3:0] always 0.
REQ-012 pmem_read / pmem_write  out  1 each  physical memory strobes, held until pmem_resp.
REQ-013 pmem_wdata  out  128  victim line; pmem_rdata  in  128  fill line; pmem_resp  in  1  completion.

Function
REQ-014 Storage per set per way: valid, dirty, TAGW-bit tag, 128-bit line, log2(WAYS)-bit LRU age (omitted when WAYS=1); write-back, write-allocate.
REQ-015 FSM states IDLE, CHECK, WRITEBACK, ALLOCATE.
REQ-016 IDLE: (mem_read|mem_write) -> CHECK next cycle; otherwise stay.
REQ-017 CHECK hit (valid & tag match in any way): mem_resp=1 this cycle, -> IDLE; read hit latency 2 cycles from request.
REQ-018 CHECK write hit: merge mem_wdata into word [3:1] per mem_byte_enable, set dirty, at the same edge.
REQ-019 CHECK miss: victim dirty -> WRITEBACK, else -> ALLOCATE; mem_resp=0.
REQ-020 Victim = lowest-index invalid way; if all valid, way with age WAYS-1; victim fixed on leaving CHECK.
REQ-021 WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 4'b0}, pmem_wdata=victim line; on pmem_resp clear victim dirty, -> ALLOCATE.
REQ-022 ALLOCATE: pmem_read=1, pmem_address={req tag, index, 4'b0}; on pmem_resp load line, set valid, write tag, clear dirty, -> CHECK (re-check guaranteed hit).
REQ-023 LRU update on every CHECK hit of way w: ages < old age(w) increment, age(w)=0, others unchanged; ages remain a permutation of 0..WAYS-1.
REQ-024 mem_read and mem_write both high: treated as write.
REQ-025 mem_rdata valid whenever mem_resp=1; otherwise don't-care.
REQ-026 pmem_read and pmem_write never both high; pmem strobes low outside WRITEBACK/ALLOCATE.
REQ-027 Request dropped before mem_resp: behaviour undefined; request in cycle after mem_resp is a new request.

Reset
REQ-028 reset high at any edge: state IDLE, all valid and dirty 0, age of way k in every set = k; line and tag contents not cleared.
REQ-029 Outputs during and one cycle after reset: mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0; reset mid-WRITEBACK/ALLOCATE abandons the transfer.

Verification (WAYS=2, SETS=8; 0x1234 -> index 3, tag 0x024)
REQ-030 Cold read 0x1234, pmem_rdata word2=0xBEEF -> pmem_read with pmem_address 0x1230, no pmem_write, single mem_resp with mem_rdata 0xBEEF.
REQ-031 Then write 0x1234, wdata 0xAA55, byte_enable 01 -> mem_resp 2 cycles after request, no pmem traffic; read 0x1234 returns 0xBE55.
REQ-032 Then read 0x12B4 (same set, miss, clean fill), read 0x1334 -> LRU victim is 0x1230 line: pmem_write at 0x1230 with word2=0xBE55, then pmem_read 0x1330.
REQ-033 After reset: read A=0x1230, read B=0x12B0, read A, read C=0x1330 -> B evicted with no pmem_write (clean); subsequent read A hits with no pmem traffic.
REQ-034 Reset asserted during ALLOCATE with pmem_resp withheld -> pmem_read 0 next cycle, mem_resp never pulses; later read of same address misses and refetches.
REQ-035 WAYS=4, SETS=4: five distinct tags to one set, reads only -> first four fills no eviction, fifth replaces the least-recently-hit way per REQ-023.
